if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
Parametrised instruction buffer between the fetch and decode stages. It generalises the single-entry IF/ID register into a DEPTH-entry FIFO of (pc, inst) pairs with a valid/ready handshake on both sides. A branch flush discards all buffered entries, and a bubble (zero pc/inst) is presented whenever the buffer is empty. Fetch can run ahead while decode is stalled, up to DEPTH entries.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
ADDR_W, 32, pc width
INST_W, 32, instruction width
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_valid_i  in  1  fetch presents a valid (pc, inst)
if_pc_i  in  ADDR_W  fetched pc
if_inst_i  in  INST_W  fetched instruction
if_ready_o  out  1  buffer can accept an entry this cycle
id_ready_i  in  1  decode consumes the head entry this cycle (deasserted = decode stall)
flush_i  in  1  branch/jump redirect; discard all entries
id_valid_o  out  1  head entry valid
id_pc_o  out  ADDR_W  head pc; zero when not valid
id_inst_o  out  INST_W  head instruction; zero when not valid (bubble)
count_o  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset: rst=1 at a posedge clears rd_ptr, wr_ptr and count to 0. After reset, id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0 and if_ready_o=1. Storage contents are don't-care. Reset has priority over every other input.
- Pointers are log2(DEPTH) bits and wrap naturally. Full = (count==DEPTH). Empty = (count==0).
- if_ready_o = !full. It is combinational from registered count only and has no path from id_ready_i or flush_i.
- push = if_valid_i & if_ready_o & !flush_i.
- pop = id_valid_o & id_ready_i & !flush_i.
- id_valid_o = !empty. id_pc_o and id_inst_o show mem[rd_ptr] when valid and are forced to zero when empty.
- Latency: an entry pushed at edge N is visible at the head after edge N. If the buffer was empty, id_valid_o rises in the cycle after the push. There is no same-cycle bypass.
- Push only: write at wr_ptr, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Simultaneous push and pop (not full, not empty): both pointers advance and count is unchanged.
- Full: if_ready_o=0. A pop in this cycle does not enable a same-cycle push. The push becomes possible in the following cycle.
- Empty with id_ready_i=1: no pop occurs and the output stays a bubble.
- Flush: rd_ptr, wr_ptr and count are cleared at the next edge. Any concurrent push or pop is discarded. The cycle after a flush always shows id_valid_o=0 and zero outputs. A new push is accepted in the cycle after the flush.
- Flush together with rst: reset behaviour applies.
- Stall: id_ready_i=0 holds the head entry and its outputs stable while fetch continues filling until full.
- Counter arithmetic: count never exceeds DEPTH and never underflows. Either condition is an assertion failure in simulation.

Decomposition:
- Shared package/defines: ZeroWord, RstEnable, True/False, and the InstAddrBus/InstBus widths, reused as the ADDR_W/INST_W defaults.
- One sub-module: if_id_queue_mem, a DEPTH x (ADDR_W+INST_W) register array with one write port and one asynchronous read port and no reset.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset then idle: after rst, count_o=0, if_ready_o=1, id_valid_o=0, and id_pc_o=id_inst_o=0 for 5 cycles.
- Single pass-through: push (pc=0x100, inst=0x00500093) with id_ready_i=1. The following cycle shows id_valid_o=1 with those values; the cycle after that returns to a bubble, with count_o back to 0.
- Stall fill: id_ready_i=0, push pcs 0x0/0x4/0x8/0xC. count_o reaches 4, if_ready_o=0, and the 5th push (0x10) is not accepted. Releasing the stall drains 0x0,0x4,0x8,0xC in order, one per cycle, and 0x10 is accepted once count_o <= 3.
- Simultaneous push/pop at count=2: count_o stays 2 and output order is preserved across pointer wrap over 12 continuous entries.
- Flush with 3 entries plus a concurrent push and pop: the next cycle shows count_o=0, id_valid_o=0 and zero outputs. A push of pc=0x200 in the following cycle appears at the head one cycle later.
- Reset mid-operation with 3 entries and flush_i=1 asserted together with rst: count_o=0, outputs are zero, and previously buffered entries never reappear.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue.
//   InstAddrBus / InstBus : default pc / instruction widths
//   ZeroWord              : bubble value shown on an empty head
//   RstEnable             : asserted level of rst
//   True / False          : single-bit logic levels
package if_id_queue_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;
  localparam logic        True      = 1'b1;
  localparam logic        False     = 1'b0;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: DEPTH x WIDTH register array,
// one synchronous write port, one asynchronous read port, no reset.
// Ports:
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (combinational from raddr)
module if_id_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of (pc, inst) pairs between
// fetch and decode with valid/ready handshakes on both sides. A flush
// discards every buffered entry; an empty queue presents a zero bubble.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   if_valid_i   fetch offers (if_pc_i, if_inst_i)
//   if_ready_o   queue not full (depends on registered count only)
//   id_ready_i   decode consumes the head this cycle
//   flush_i      redirect: drop all entries at the next edge
//   id_valid_o   head entry valid
//   id_pc_o      head pc, zero when empty
//   id_inst_o    head instruction, zero when empty
//   count_o      occupancy 0..DEPTH
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [INST_W-1:0] if_inst_i,
  output logic              if_ready_o,
  input  logic              id_ready_i,
  input  logic              flush_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + INST_W;
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  assign full  = (count == CntFull) ? True : False;
  assign empty = (count == '0) ? True : False;

  // Ready comes only from registered count so fetch never sees a
  // combinational path from decode's ready or the flush line.
  assign if_ready_o = ~full;
  assign id_valid_o = ~empty;

  assign push = if_valid_i & if_ready_o & ~flush_i;
  assign pop  = id_valid_o & id_ready_i & ~flush_i;

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({if_pc_i, if_inst_i}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Stale storage is masked to a bubble whenever the queue is empty.
  assign id_pc_o   = empty ? ADDR_W'(ZeroWord) : head[ENT_W-1:INST_W];
  assign id_inst_o = empty ? INST_W'(ZeroWord) : head[INST_W-1:0];
  assign count_o   = count;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst != RstEnable && !flush_i) begin
      assert (!(push && !pop && count == CntFull))
        else $error("if_id_queue: occupancy overflow");
      assert (!(pop && !push && count == '0))
        else $error("if_id_queue: occupancy underflow");
      assert (count <= CntFull)
        else $error("if_id_queue: count above DEPTH");
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic [31:0] if_inst_i;
  logic        if_ready_o;
  logic        id_ready_i;
  logic        flush_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: ordered list of buffered (pc, inst) pairs.
  logic [63:0] q[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid_i (if_valid_i),
    .if_pc_i    (if_pc_i),
    .if_inst_i  (if_inst_i),
    .if_ready_o (if_ready_o),
    .id_ready_i (id_ready_i),
    .flush_i    (flush_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] h;
      h = (q.size() > 0) ? q[0] : 64'h0;
      chk("model_count", 64'(count_o), 64'(q.size()));
      chk("model_if_ready", 64'(if_ready_o), 64'(q.size() < DEPTH));
      chk("model_id_valid", 64'(id_valid_o), 64'(q.size() > 0));
      chk("model_id_pc", 64'(id_pc_o), 64'(h[63:32]));
      chk("model_id_inst", 64'(id_inst_o), 64'(h[31:0]));
    end
  end

  // One clock cycle: apply inputs, advance the model at the edge, and
  // return at the following negedge when outputs are settled.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic rdy, input logic fl, input logic r);
    bit do_push, do_pop;
    if_valid_i = v;
    if_pc_i    = pc;
    if_inst_i  = inst;
    id_ready_i = rdy;
    flush_i    = fl;
    rst        = r;
    do_push = !r && !fl && v && (q.size() < DEPTH);
    do_pop  = !r && !fl && rdy && (q.size() > 0);
    @(posedge clk);
    if (r || fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({pc, inst});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_pc;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_ready", 64'(if_ready_o), 64'd1);
      chk("rst_valid", 64'(id_valid_o), 64'd0);
      chk("rst_pc", 64'(id_pc_o), 64'd0);
      chk("rst_inst", 64'(id_inst_o), 64'd0);
    end

    // Single pass-through.
    cyc(1'b1, 32'h100, 32'h0050_0093, 1'b1, 1'b0, 1'b0);
    chk("pass_valid", 64'(id_valid_o), 64'd1);
    chk("pass_pc", 64'(id_pc_o), 64'h100);
    chk("pass_inst", 64'(id_inst_o), 64'h0050_0093);
    idle(1'b1);
    chk("pass_bubble_valid", 64'(id_valid_o), 64'd0);
    chk("pass_bubble_inst", 64'(id_inst_o), 64'd0);
    chk("pass_count", 64'(count_o), 64'd0);

    // Stall fill to full, fifth push refused.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'(4 * i), 32'h1300_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    end
    chk("fill_count", 64'(count_o), 64'd4);
    chk("fill_ready", 64'(if_ready_o), 64'd0);
    chk("fill_head_stable", 64'(id_pc_o), 64'h0);
    cyc(1'b1, 32'h10, 32'h1300_0010, 1'b0, 1'b0, 1'b0);
    chk("fill_5th_refused", 64'(count_o), 64'd4);
    chk("fill_head_held", 64'(id_pc_o), 64'h0);
    // Release: 0x10 keeps being offered and enters once there is room.
    cyc(1'b1, 32'h10, 32'h1300_0010, 1'b1, 1'b0, 1'b0);
    chk("drain_no_same_cycle_push", 64'(count_o), 64'd3);
    chk("drain_pc1", 64'(id_pc_o), 64'h4);
    cyc(1'b1, 32'h10, 32'h1300_0010, 1'b1, 1'b0, 1'b0);
    chk("drain_push_accepted", 64'(count_o), 64'd3);
    chk("drain_pc2", 64'(id_pc_o), 64'h8);
    idle(1'b1);
    chk("drain_pc3", 64'(id_pc_o), 64'hC);
    idle(1'b1);
    chk("drain_pc4", 64'(id_pc_o), 64'h10);
    idle(1'b1);
    chk("drain_empty", 64'(id_valid_o), 64'd0);

    // Continuous push/pop at count=2 across pointer wrap.
    cyc(1'b1, 32'h1000, 32'hA000_0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h1004, 32'hA000_0001, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      exp_pc = 32'h1000 + 32'(4 * k);
      chk("wrap_head_pc", 64'(id_pc_o), 64'(exp_pc));
      cyc(1'b1, 32'h1008 + 32'(4 * k), 32'hA000_0002 + 32'(k), 1'b1, 1'b0, 1'b0);
      chk("wrap_count", 64'(count_o), 64'd2);
    end
    idle(1'b1);
    idle(1'b1);
    chk("wrap_drained", 64'(count_o), 64'd0);

    // Flush with 3 entries plus concurrent push and pop.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(4 * i), 32'h33, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h3FC, 32'h44, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(id_valid_o), 64'd0);
    chk("flush_pc", 64'(id_pc_o), 64'd0);
    cyc(1'b1, 32'h200, 32'h55, 1'b0, 1'b0, 1'b0);
    chk("post_flush_pc", 64'(id_pc_o), 64'h200);
    chk("post_flush_count", 64'(count_o), 64'd1);

    // Reset together with flush while holding 3 entries.
    cyc(1'b1, 32'h204, 32'h66, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h208, 32'h77, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count_o), 64'd3);
    cyc(1'b1, 32'h20C, 32'h88, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_count", 64'(count_o), 64'd0);
    chk("mid_rst_pc", 64'(id_pc_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("mid_rst_no_ghost", 64'(id_valid_o), 64'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 199) == 0));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
